draw_scn_gen: RTL

//  Parametrised successor of the fixed-size LCD screen painter. On init_draw it paints one of
//  N_SCN stored screens (external pixel ROM) onto an H_RES x V_RES LCD via a valid/ready

---
 rtl/draw_scn_gen.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/draw_scn_gen.sv
// Paints one stored screen (or, with SOLID_FILL_EN, a solid colour) onto the LCD as an
// 11-word address-window header followed by H_RES*V_RES pixels; the valid/ready stream stalls losslessly.
module draw_scn_gen #(
   parameter int H_RES   = 240,
   parameter int V_RES   = 320,
   parameter int PIX_W   = 16,
   parameter int N_SCN   = 16,
   parameter int RST_CYC = 34815,
   localparam int SCN_W  = $clog2(N_SCN),
   localparam int AW     = $clog2(N_SCN * H_RES * V_RES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init_draw,
`ifdef SOLID_FILL_EN
   input  logic [SCN_W:0]   opt_scn,
   input  logic [PIX_W-1:0] fill_col,
`else
   input  logic [SCN_W-1:0] opt_scn,
`endif
   output logic             busy,
   output logic             done_draw,
   output logic             draw_err,
   output logic [AW-1:0]    rom_addr,
   input  logic [PIX_W-1:0] rom_data,
   output logic [PIX_W-1:0] lcd_dat,
   output logic             lcd_dc,
   output logic             lcd_valid,
   input  logic             lcd_ready
);
   localparam int NPIX = H_RES * V_RES;
   localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int FW = $clog2(NPIX + 1);
   localparam int WW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
   localparam logic [15:0] HL = 16'(H_RES - 1);
   localparam logic [15:0] VL = 16'(V_RES - 1);

   typedef enum logic [2:0] {WAIT_RST, IDLE, HDR, PIX, DONE} state_t;
   state_t state;

   logic [WW-1:0]    wcnt;
   logic [3:0]       hidx;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [FW-1:0]    fcnt;
   logic [SCN_W-1:0] scn_q;
   logic             iss, rv, bvld, fill_q, err_lock;
   logic [PIX_W-1:0] bdat, fill_dat;

   logic             fill_req;
   logic [SCN_W-1:0] scn_idx;
   logic [PIX_W-1:0] fill_src;
`ifdef SOLID_FILL_EN
   assign fill_req = opt_scn[SCN_W];
   assign scn_idx  = opt_scn[SCN_W-1:0];
   assign fill_src = fill_col;
`else
   assign fill_req = 1'b0;
   assign scn_idx  = opt_scn;
   assign fill_src = '0;
`endif

   // {dc, byte} for each header word position
   function automatic logic [8:0] hdr_word(input logic [3:0] i);
      case (i)
         4'd0:       hdr_word = 9'h02A;
         4'd1, 4'd2: hdr_word = 9'h100;
         4'd3:       hdr_word = {1'b1, HL[15:8]};
         4'd4:       hdr_word = {1'b1, HL[7:0]};
         4'd5:       hdr_word = 9'h02B;
         4'd6, 4'd7: hdr_word = 9'h100;
         4'd8:       hdr_word = {1'b1, VL[15:8]};
         4'd9:       hdr_word = {1'b1, VL[7:0]};
         default:    hdr_word = 9'h02C;
      endcase
   endfunction

   logic       out_free, acc, last_pix, b_next, fetch_more;
   logic [8:0] hw_next;
   always_comb begin
      out_free   = !lcd_valid || lcd_ready;
      acc        = lcd_valid && lcd_ready;
      last_pix   = (col == CW'(H_RES - 1)) && (row == RW'(V_RES - 1));
      // The ROM word on rom_data lands in the buffer unless it goes straight to the output,
      // or stays on the ROM bus because rom_addr was held.
      b_next     = bvld ? (!out_free || rv) : (rv && !out_free);
      fetch_more = (fcnt != FW'(NPIX));
      hw_next    = hdr_word(hidx + 4'd1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= WAIT_RST;  wcnt <= '0;       busy <= 1'b1;
         done_draw <= 1'b0;  draw_err <= 1'b0; lcd_valid <= 1'b0;
         lcd_dat <= '0;      lcd_dc <= 1'b0;   rom_addr <= '0;
         hidx <= '0;         col <= '0;        row <= '0;
         fcnt <= '0;         scn_q <= '0;      iss <= 1'b0;
         rv <= 1'b0;         bvld <= 1'b0;     bdat <= '0;
         fill_q <= 1'b0;     fill_dat <= '0;   err_lock <= 1'b0;
      end else begin
         done_draw <= 1'b0;
         draw_err  <= 1'b0;
         case (state)
            WAIT_RST: begin
               if (wcnt == WW'(RST_CYC - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            IDLE: begin
               if (!init_draw) begin
                  err_lock <= 1'b0;
               end else if (!err_lock) begin
                  if (!fill_req && int'(scn_idx) >= N_SCN) begin
                     draw_err <= 1'b1;
                     err_lock <= 1'b1;
                  end else begin
                     state <= HDR;        busy <= 1'b1;
                     scn_q <= scn_idx;    fill_q <= fill_req;  fill_dat <= fill_src;
                     hidx <= '0;          lcd_valid <= 1'b1;
                     lcd_dc <= 1'b0;      lcd_dat <= PIX_W'(8'h2A);
                  end
               end
            end
            HDR: begin
               if (acc) begin
                  if (hidx == 4'd10) begin
                     state <= PIX;  lcd_valid <= 1'b0;
                     col <= '0;     row <= '0;
                     rv <= 1'b0;    bvld <= 1'b0;
                     if (!fill_q) begin
                        rom_addr <= AW'(scn_q) * AW'(NPIX);
                        iss      <= 1'b1;
                        fcnt     <= FW'(1);
                     end else begin
                        iss  <= 1'b0;
                        fcnt <= '0;
                     end
                  end else begin
                     hidx    <= hidx + 4'd1;
                     lcd_dc  <= hw_next[8];
                     lcd_dat <= PIX_W'(hw_next[7:0]);
                  end
               end
            end
            PIX: begin
               if (acc) begin
                  if (col == CW'(H_RES - 1)) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
               if (acc && last_pix) begin
                  state <= DONE;  lcd_valid <= 1'b0;  done_draw <= 1'b1;
                  iss <= 1'b0;    rv <= 1'b0;         bvld <= 1'b0;
               end else if (fill_q) begin
                  if (out_free) begin
                     lcd_valid <= 1'b1;
                     lcd_dc    <= 1'b1;
                     lcd_dat   <= fill_dat;
                  end
               end else begin
                  if (out_free) begin
                     lcd_dc <= 1'b1;
                     if (bvld) begin
                        lcd_valid <= 1'b1;
                        lcd_dat   <= bdat;
                     end else if (rv) begin
                        lcd_valid <= 1'b1;
                        lcd_dat   <= rom_data;
                     end else begin
                        lcd_valid <= 1'b0;
                     end
                  end
                  if (rv && (bvld ? out_free : !out_free))
                     bdat <= rom_data;
                  bvld <= b_next;
                  // A held rom_addr keeps re-presenting the same word, so an unconsumed word survives.
                  rv <= iss || (rv && bvld && !out_free);
                  if (fetch_more && !b_next) begin
                     rom_addr <= rom_addr + 1'b1;
                     fcnt     <= fcnt + 1'b1;
                     iss      <= 1'b1;
                  end else begin
                     iss <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= WAIT_RST;
         endcase
      end
   end
endmodule
